// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB-to-I2C bridge.
// Contents: register byte offsets, CTRL/STATUS bit positions and the
// transaction FSM state encoding used by apb_i2c_bridge.
package apb_i2c_pkg;

    // Register byte offsets
    localparam int REG_CTRL   = 0;
    localparam int REG_ID     = 1;
    localparam int REG_MADDR  = 2;
    localparam int REG_WDATA  = 3;
    localparam int REG_RDATA  = 4;
    localparam int REG_STATUS = 5;

    // CTRL bits
    localparam int CTRL_START = 0;
    localparam int CTRL_RW    = 1;
    localparam int CTRL_IE    = 2;

    // STATUS bits
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;
    localparam int ST_TOUT = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/apb_i2c_timeout.sv
// Transaction timeout counter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the counter (asserted the cycle before WAIT begins)
//   enable     : count this cycle (asserted while waiting for the master)
//   expired    : counter has reached TIMEOUT-1 while enabled
module apb_i2c_timeout #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so it can never wrap back to a fresh timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/apb_i2c_bridge.sv
// APB3 register front-end that launches single-byte I2C transactions.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr : APB3 slave
//   i2c_req/i2c_rw/i2c_id/i2c_addr/i2c_wdata : request to the I2C master
//   i2c_ack/i2c_rdata/i2c_err                : completion from the master
//   irq                     : level interrupt, DONE & IE
module apb_i2c_bridge
    import apb_i2c_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              i2c_req,
    output logic              i2c_rw,
    output logic [7:0]        i2c_id,
    output logic [7:0]        i2c_addr,
    output logic [DATA_W-1:0] i2c_wdata,
    input  logic              i2c_ack,
    input  logic [DATA_W-1:0] i2c_rdata,
    input  logic              i2c_err,
    output logic              irq
);

    state_t state, state_next;

    logic              ctrl_rw, ctrl_ie;
    logic [7:0]        id_reg, maddr_reg;
    logic [DATA_W-1:0] wdata_reg, rdata_reg;
    logic              busy, done, err, tout;

    logic access, bad, wr_ok, start_go, expired;
    logic sel_ctrl, sel_id, sel_maddr, sel_wdata, sel_rdata, sel_status, addr_bad;

    assign access     = psel & penable;
    assign sel_ctrl   = (paddr == ADDR_W'(REG_CTRL));
    assign sel_id     = (paddr == ADDR_W'(REG_ID));
    assign sel_maddr  = (paddr == ADDR_W'(REG_MADDR));
    assign sel_wdata  = (paddr == ADDR_W'(REG_WDATA));
    assign sel_rdata  = (paddr == ADDR_W'(REG_RDATA));
    assign sel_status = (paddr == ADDR_W'(REG_STATUS));
    assign addr_bad   = (paddr > ADDR_W'(REG_STATUS));

    // Configuration registers are frozen while a transaction is in flight;
    // STATUS stays writable so software can clear flags at any time.
    assign bad = addr_bad
               | (pwrite & sel_rdata)
               | (pwrite & busy & (sel_ctrl | sel_id | sel_maddr | sel_wdata));

    assign pslverr  = access & bad;
    assign pready   = 1'b1;
    assign wr_ok    = access & pwrite & ~bad;
    assign start_go = wr_ok & sel_ctrl & pwdata[CTRL_START];
    assign irq      = done & ctrl_ie;

    apb_i2c_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == S_ISSUE),
        .enable  (state == S_WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_go) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (i2c_ack || expired) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        i2c_req = 1'b0;
        case (state)
            S_ISSUE, S_WAIT: i2c_req = 1'b1;
            default:         i2c_req = 1'b0;
        endcase
    end

    // Register file. Hardware updates come after the APB write so that a
    // same-cycle hardware set of a STATUS flag overrides a software clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_rw   <= 1'b0;
            ctrl_ie   <= 1'b0;
            id_reg    <= '0;
            maddr_reg <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            tout      <= 1'b0;
            i2c_rw    <= 1'b0;
            i2c_id    <= '0;
            i2c_addr  <= '0;
            i2c_wdata <= '0;
        end else begin
            if (wr_ok) begin
                if (sel_ctrl) begin
                    ctrl_rw <= pwdata[CTRL_RW];
                    ctrl_ie <= pwdata[CTRL_IE];
                end
                if (sel_id)    id_reg    <= pwdata[7:0];
                if (sel_maddr) maddr_reg <= pwdata[7:0];
                if (sel_wdata) wdata_reg <= pwdata;
                if (sel_status) begin
                    if (pwdata[ST_DONE]) done <= 1'b0;
                    if (pwdata[ST_ERR])  err  <= 1'b0;
                    if (pwdata[ST_TOUT]) tout <= 1'b0;
                end
            end
            if (start_go) begin
                i2c_id    <= id_reg;
                i2c_addr  <= maddr_reg;
                i2c_wdata <= wdata_reg;
                i2c_rw    <= pwdata[CTRL_RW];
                busy      <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
                tout      <= 1'b0;
            end
            // An ack in the expiry cycle takes priority over the timeout.
            if (state == S_WAIT) begin
                if (i2c_ack) begin
                    err  <= i2c_err;
                    tout <= 1'b0;
                    if (i2c_rw) rdata_reg <= i2c_rdata;
                end else if (expired) begin
                    err  <= 1'b1;
                    tout <= 1'b1;
                end
            end
            if (state == S_DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    always_comb begin
        prdata = '0;
        if (access) begin
            if (sel_ctrl) begin
                prdata[CTRL_RW] = ctrl_rw;
                prdata[CTRL_IE] = ctrl_ie;
            end
            if (sel_id)    prdata = DATA_W'(id_reg);
            if (sel_maddr) prdata = DATA_W'(maddr_reg);
            if (sel_wdata) prdata = wdata_reg;
            if (sel_rdata) prdata = rdata_reg;
            if (sel_status) begin
                prdata[ST_BUSY] = busy;
                prdata[ST_DONE] = done;
                prdata[ST_ERR]  = err;
                prdata[ST_TOUT] = tout;
            end
        end
    end

endmodule
